// File: rtl/icache_assoc.sv
// Set-associative instruction cache with halfword-aligned 32-bit fetch and whole-line refill.
// A single fill engine (IDLE -> FILL -> WRITE) services one missing line at a time.
module icache_assoc #(
  parameter int SET_BIT  = 4,
  parameter int WAY      = 2,
  parameter int LINE_BIT = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        inst_valid,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic [31:0] inst_res,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_result,
  input  logic        mem_ready,
  input  logic        rob_clear
);
  localparam int SETS  = 1 << SET_BIT;
  localparam int WORDS = 1 << LINE_BIT;
  localparam int TAG_W = 32 - SET_BIT - LINE_BIT - 2;
  localparam int CNT_W = (LINE_BIT > 0) ? LINE_BIT : 1;
  localparam int VW    = (WAY > 1) ? $clog2(WAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_WRITE = 2'd2} state_e;

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return a[31 -: TAG_W];
  endfunction

  function automatic logic [SET_BIT-1:0] set_of(input logic [31:0] a);
    return a[LINE_BIT+2 +: SET_BIT];
  endfunction

  function automatic logic [CNT_W-1:0] word_of(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) & 32'(WORDS - 1);
    return w[CNT_W-1:0];
  endfunction

  function automatic logic [VW-1:0] victim_adv(input logic [VW-1:0] v);
    return (int'(v) >= WAY - 1) ? {VW{1'b0}} : v + VW'(1);
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [TAG_W-1:0]   fill_tag_q;
  logic [SET_BIT-1:0] fill_set_q;
  logic [31:0]        line_buf_q [WORDS];
  logic               inst_ready_q;
  logic [31:0]        inst_res_q;

  logic [WAY-1:0]     valid_q  [SETS];
  logic [VW-1:0]      victim_q [SETS];
  logic [TAG_W-1:0]   tag_q    [SETS][WAY];
  logic [31:0]        data_q   [SETS][WAY][WORDS];

  logic [31:0]        addr2_s;
  logic [TAG_W-1:0]   tag_a_s, tag_b_s;
  logic [SET_BIT-1:0] set_a_s, set_b_s;
  logic [CNT_W-1:0]   wsel_a_s, wsel_b_s;
  logic [WAY-1:0]     match_a_s, match_b_s;
  logic [VW-1:0]      way_a_s, way_b_s;
  logic               hit_a_s, hit_b_s, hit_s, lookup_ok_s;
  logic [31:0]        word_a_s, word_b_s, res_s;
  logic [TAG_W-1:0]   miss_tag_s;
  logic [SET_BIT-1:0] miss_set_s;
  logic [31:0]        fill_addr_s;
  logic               mem_valid_s;
  logic [31:0]        mem_addr_s;

  // The second halfword of an RVC-straddling fetch comes from the next line (set+1, wrapping).
  assign addr2_s  = inst_addr + 32'd2;
  assign tag_a_s  = tag_of(inst_addr);
  assign set_a_s  = set_of(inst_addr);
  assign wsel_a_s = word_of(inst_addr);
  assign tag_b_s  = tag_of(addr2_s);
  assign set_b_s  = set_of(addr2_s);
  assign wsel_b_s = word_of(addr2_s);

  // Tag compare of both candidate lines across all ways.
  always_comb begin
    match_a_s = '0;
    match_b_s = '0;
    way_a_s   = '0;
    way_b_s   = '0;
    for (int w = 0; w < WAY; w++) begin
      match_a_s[w] = valid_q[set_a_s][w] && (tag_q[set_a_s][w] == tag_a_s);
      match_b_s[w] = valid_q[set_b_s][w] && (tag_q[set_b_s][w] == tag_b_s);
      way_a_s      = match_a_s[w] ? VW'(w) : way_a_s;
      way_b_s      = match_b_s[w] ? VW'(w) : way_b_s;
    end
  end

  assign hit_a_s     = |match_a_s;
  assign hit_b_s     = |match_b_s;
  assign hit_s       = hit_a_s && (!inst_addr[1] || hit_b_s);
  assign word_a_s    = data_q[set_a_s][way_a_s][wsel_a_s];
  assign word_b_s    = data_q[set_b_s][way_b_s][wsel_b_s];
  assign res_s       = inst_addr[1] ? {word_b_s[15:0], word_a_s[31:16]} : word_a_s;
  assign lookup_ok_s = (state_q == S_IDLE) && inst_valid && !rob_clear && hit_s;
  assign miss_tag_s  = hit_a_s ? tag_b_s : tag_a_s;
  assign miss_set_s  = hit_a_s ? set_b_s : set_a_s;
  assign fill_addr_s = (32'({fill_tag_q, fill_set_q}) << (LINE_BIT + 2)) | (32'(cnt_q) << 2);

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a flushed lookup never launches a fill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (inst_valid && !rob_clear && !hit_s) ? S_FILL : S_IDLE;
      S_FILL:  state_d = (mem_ready && cnt_q == CNT_LAST) ? S_WRITE : S_FILL;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the memory request is decoded purely from state.
  always_comb begin
    mem_valid_s = 1'b0;
    mem_addr_s  = 32'd0;
    case (state_q)
      S_FILL: begin
        mem_valid_s = 1'b1;
        mem_addr_s  = fill_addr_s;
      end
      default: begin
        mem_valid_s = 1'b0;
        mem_addr_s  = 32'd0;
      end
    endcase
  end

  // Control registers: fetch response, fill bookkeeping, valid bits and victim pointers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q        <= '0;
      fill_tag_q   <= '0;
      fill_set_q   <= '0;
      inst_ready_q <= 1'b0;
      inst_res_q   <= 32'd0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
      end
    end else if (rdy_in) begin
      inst_ready_q <= lookup_ok_s;
      if (rob_clear) begin
        inst_res_q <= 32'd0;
      end else if (lookup_ok_s) begin
        inst_res_q <= res_s;
      end
      if (state_q == S_IDLE && state_d == S_FILL) begin
        fill_tag_q <= miss_tag_s;
        fill_set_q <= miss_set_s;
        cnt_q      <= '0;
      end
      if (state_q == S_FILL && mem_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == S_WRITE) begin
        valid_q[fill_set_q][victim_q[fill_set_q]] <= 1'b1;
        victim_q[fill_set_q] <= victim_adv(victim_q[fill_set_q]);
      end
    end
  end

  // Line buffer capture and array install; tags and data are never reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rst_in) begin
      if (state_q == S_FILL && mem_ready) begin
        line_buf_q[cnt_q] <= mem_result;
      end
      if (state_q == S_WRITE) begin
        tag_q[fill_set_q][victim_q[fill_set_q]] <= fill_tag_q;
        for (int i = 0; i < WORDS; i++) begin
          data_q[fill_set_q][victim_q[fill_set_q]][i] <= line_buf_q[i];
        end
      end
    end
  end

  assign inst_ready = inst_ready_q;
  assign inst_res   = inst_res_q;
  assign mem_valid  = mem_valid_s;
  assign mem_addr   = mem_addr_s;
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc (SET_BIT=4, WAY=2, LINE_BIT=2) with a synthetic memory image.
module tb_icache_assoc;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, inst_valid, mem_ready, rob_clear;
  logic [31:0] inst_addr, mem_result;
  logic        inst_ready, mem_valid;
  logic [31:0] inst_res, mem_addr;
  int          npass = 0;
  int          ntot  = 0;
  logic [31:0] wa, wb;

  icache_assoc #(.SET_BIT(4), .WAY(2), .LINE_BIT(2)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .inst_valid (inst_valid),
    .inst_addr  (inst_addr),
    .inst_ready (inst_ready),
    .inst_res   (inst_res),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_result (mem_result),
    .mem_ready  (mem_ready),
    .rob_clear  (rob_clear)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One memory reply for the word the cache should be requesting.
  task automatic serve_word(input logic [31:0] a);
    chk("fill_valid", {31'd0, mem_valid}, 32'd1);
    chk("fill_addr", mem_addr, a);
    mem_ready  = 1'b1;
    mem_result = memw(a);
    tick;
    mem_ready  = 1'b0;
    mem_result = 32'd0;
  endtask

  task automatic serve_fill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) serve_word(base + 32'(4 * i));
  endtask

  // WRITE cycle, then the IDLE re-lookup cycle.
  task automatic wait_install;
    chk("write_mv", {31'd0, mem_valid}, 32'd0);
    chk("write_ir", {31'd0, inst_ready}, 32'd0);
    tick;
    chk("relook_ir", {31'd0, inst_ready}, 32'd0);
    chk("relook_mv", {31'd0, mem_valid}, 32'd0);
    tick;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; inst_valid = 1'b0; inst_addr = 32'd0;
    mem_ready = 1'b0; mem_result = 32'd0; rob_clear = 1'b0;
    tick; tick;
    rst_in = 1'b0;
    chk("rst_ir", {31'd0, inst_ready}, 32'd0);
    chk("rst_res", inst_res, 32'd0);
    chk("rst_mv", {31'd0, mem_valid}, 32'd0);
    chk("rst_ma", mem_addr, 32'd0);

    // Cold miss on 0x100
    inst_valid = 1'b1; inst_addr = 32'h100;
    tick;
    chk("cold_ir", {31'd0, inst_ready}, 32'd0);
    serve_fill(32'h100);
    wait_install;
    chk("cold_ir1", {31'd0, inst_ready}, 32'd1);
    chk("cold_res", inst_res, memw(32'h100));

    // Hit after fill
    inst_addr = 32'h108;
    tick;
    chk("hit_ir", {31'd0, inst_ready}, 32'd1);
    chk("hit_res", inst_res, memw(32'h108));
    chk("hit_mv", {31'd0, mem_valid}, 32'd0);

    // Line-straddling RVC fetch: only line 0x110 is fetched
    inst_addr = 32'h10E;
    tick;
    chk("rvc_ir", {31'd0, inst_ready}, 32'd0);
    serve_fill(32'h110);
    wait_install;
    wa = memw(32'h10C);
    wb = memw(32'h110);
    chk("rvc_ir1", {31'd0, inst_ready}, 32'd1);
    chk("rvc_res", inst_res, {wb[15:0], wa[31:16]});

    // Reset, then eviction in set 0
    rst_in = 1'b1; inst_valid = 1'b0;
    tick;
    rst_in = 1'b0;
    inst_valid = 1'b1; inst_addr = 32'h000;
    tick;
    serve_fill(32'h000);
    wait_install;
    chk("ev0_res", inst_res, memw(32'h000));
    inst_addr = 32'h100;
    tick;
    chk("ev1_miss", {31'd0, mem_valid}, 32'd1);
    serve_fill(32'h100);
    wait_install;
    chk("ev1_res", inst_res, memw(32'h100));
    inst_addr = 32'h200;
    tick;
    serve_fill(32'h200);
    wait_install;
    chk("ev2_res", inst_res, memw(32'h200));
    inst_addr = 32'h104;
    tick;
    chk("ev_hit_ir", {31'd0, inst_ready}, 32'd1);
    chk("ev_hit_res", inst_res, memw(32'h104));
    chk("ev_hit_mv", {31'd0, mem_valid}, 32'd0);
    inst_addr = 32'h000;
    tick;
    chk("ev_miss_ir", {31'd0, inst_ready}, 32'd0);
    serve_fill(32'h000);
    wait_install;
    chk("ev_re_res", inst_res, memw(32'h000));

    // rob_clear in the middle of a fill for 0x300
    inst_addr = 32'h300;
    tick;
    serve_word(32'h300);
    serve_word(32'h304);
    rob_clear = 1'b1; inst_valid = 1'b0;
    tick;
    rob_clear = 1'b0;
    chk("rc_mv", {31'd0, mem_valid}, 32'd1);
    chk("rc_ma", mem_addr, 32'h308);
    chk("rc_ir", {31'd0, inst_ready}, 32'd0);
    serve_word(32'h308);
    serve_word(32'h30C);
    wait_install;
    chk("rc_drop_ir", {31'd0, inst_ready}, 32'd0);
    chk("rc_drop_mv", {31'd0, mem_valid}, 32'd0);
    inst_valid = 1'b1; inst_addr = 32'h300;
    tick;
    chk("rc_hit_ir", {31'd0, inst_ready}, 32'd1);
    chk("rc_hit_res", inst_res, memw(32'h300));
    chk("rc_hit_mv", {31'd0, mem_valid}, 32'd0);
    rob_clear = 1'b1;
    tick;
    rob_clear = 1'b0;
    chk("rc_idle_ir", {31'd0, inst_ready}, 32'd0);
    chk("rc_idle_res", inst_res, 32'd0);
    tick;
    chk("rc_after_ir", {31'd0, inst_ready}, 32'd1);

    // Reset in the middle of a fill
    inst_addr = 32'h400;
    tick;
    serve_word(32'h400);
    serve_word(32'h404);
    rst_in = 1'b1;
    tick;
    rst_in = 1'b0;
    chk("rf_mv", {31'd0, mem_valid}, 32'd0);
    chk("rf_ma", mem_addr, 32'd0);
    chk("rf_ir", {31'd0, inst_ready}, 32'd0);
    chk("rf_res", inst_res, 32'd0);

    // Previously resident line misses; freeze with rdy_in low mid-fill
    inst_addr = 32'h300;
    tick;
    chk("rf_miss_ir", {31'd0, inst_ready}, 32'd0);
    serve_word(32'h300);
    rdy_in = 1'b0; mem_ready = 1'b1; mem_result = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("frz_ma", mem_addr, 32'h304);
      chk("frz_mv", {31'd0, mem_valid}, 32'd1);
    end
    rdy_in = 1'b1; mem_ready = 1'b0; mem_result = 32'd0;
    serve_word(32'h304);
    serve_word(32'h308);
    serve_word(32'h30C);
    wait_install;
    chk("frz_ir", {31'd0, inst_ready}, 32'd1);
    chk("frz_res0", inst_res, memw(32'h300));
    inst_addr = 32'h304;
    tick;
    chk("frz_res1", inst_res, memw(32'h304));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache with line-based refill. It sits between the instruction fetch unit and the memory controller. It serves 32-bit fetches from any halfword-aligned PC, including RVC fetches that straddle two cache lines. On a miss it refills whole lines through a single word-wide memory request port, driven by an internal fill state machine.

## Interface
- SET_BIT, 4, log2 of set count; must be ≥ 1.
- WAY, 2, associativity; 1, 2 or 4.
- LINE_BIT, 2, log2 of 32-bit words per line; 0..3.
- clk_in  input  1  system clock
- rst_in  input  1  reset; one clock, synchronous, active-high
- rdy_in  input  1  global ready; all state frozen when low
- inst_valid  input  1  fetch request present
- inst_addr  input  32  fetch PC; bit 0 is always 0
- inst_ready  output  1  inst_res is valid this cycle
- inst_res  output  32  fetched instruction bits
- mem_valid  output  1  word read request to memory controller
- mem_addr  output  32  word-aligned request address
- mem_result  input  32  returned word
- mem_ready  input  1  one-cycle pulse; mem_result valid; completes the request at current mem_addr
- rob_clear  input  1  pipeline flush

## Operation
- Address split: tag = [31 : SET_BIT+LINE_BIT+2], set = [SET_BIT+LINE_BIT+1 : LINE_BIT+2], word = [LINE_BIT+1 : 2]. TAG width is 32−SET_BIT−LINE_BIT−2.
- Storage per set and way: valid bit, tag, and 2^LINE_BIT data words. Each set also holds a round-robin victim pointer, log2(WAY) bits; it is absent when WAY=1.
- Fetch uses address A = inst_addr and A2 = inst_addr+2 (mod 2^32).
  - If A[1]=0, result = word(A).
  - If A[1]=1, result = {word(A2)[15:0], word(A)[31:16]}.
  - A2 can fall in the next line, which is set+1 and wraps to set 0 at the top.
- Hit means both needed words are present in a valid way with a matching tag.
- FSM states:
  - IDLE: lookup. If inst_valid and hit, register the result. If inst_valid and miss, latch the tag and set of the first missing line (line of A first, then line of A2), clear the word counter, go to FILL.
  - FILL: mem_valid=1, mem_addr={fill_tag, fill_set, cnt, 2'b00}. Each mem_ready stores mem_result into line buffer[cnt] and increments cnt. When mem_ready arrives for the last word, go to WRITE.
  - WRITE: write the line buffer, tag and valid bit into the way chosen by the set's victim pointer, advance that pointer (mod WAY), go to IDLE.
- A second missing line is handled by a fresh lookup in IDLE after the first fill completes. There is no combined fill.
- No hit-under-miss: lookups are not performed outside IDLE.
- rob_clear:
  - Clears inst_ready and inst_res the following cycle.
  - An in-progress FILL/WRITE continues to completion; the line is installed, because a memory request cannot be cancelled.
  - The pending fetch is then dropped; IDLE reacts only to the current inst_valid.
- rdy_in low: no state, output or array change; mem_ready is ignored. The memory controller is frozen by the same signal.
- rst_in:
  - Clears every valid bit and victim pointer, and returns the FSM to IDLE.
  - Aborts any fill mid-operation; the line buffer is discarded.
  - Array data and tags need not be cleared.

## Timing
- Reset values: inst_ready=0, inst_res=0, mem_valid=0, mem_addr=0.
- mem_valid and mem_addr are decoded from state: high exactly while in FILL.
  - mem_addr changes only on the edge that samples mem_ready.
  - mem_valid drops the cycle after the last mem_ready.
- Hit latency: inst_valid with a hit at edge t gives inst_ready=1 and inst_res in the cycle after t. inst_ready is a one-cycle registered pulse per request edge.
- Miss: detected at edge t; FILL runs from cycle t+1 for 2^LINE_BIT memory replies. WRITE takes one cycle, IDLE re-lookup one cycle, and inst_ready rises the cycle after that re-lookup.
- inst_ready=0 in every cycle where the FSM is not IDLE, and on any cycle where rob_clear was high at the preceding edge.
- A fill and a lookup never update the same array entry in the same cycle.

## Test plan
- Cold miss, LINE_BIT=2, inst_addr=0x100 held: mem requests 0x100, 0x104, 0x108, 0x10C in order. After WRITE plus one cycle, inst_ready=1 and inst_res=mem[0x100].
- Hit after fill: inst_addr=0x108 → inst_ready=1 the next cycle, inst_res=mem[0x108], mem_valid stays 0.
- Line-straddling RVC: line 0x100 resident, inst_addr=0x10E → fill of 0x110..0x11C only, then inst_res={mem[0x110][15:0], mem[0x10C][31:16]}.
- Eviction, WAY=2, SET_BIT=4, LINE_BIT=2: fetch 0x000, 0x100, 0x200 (same set 0) → 0x200 replaces 0x000. Refetching 0x100 hits; refetching 0x000 misses and issues request 0x000.
- rob_clear asserted mid-FILL for line 0x300 → fill completes and line 0x300 is installed, inst_ready stays 0. A later fetch of 0x300 hits with 1-cycle latency.
- Reset mid-FILL, then rdy_in=0 for 3 cycles during a fill with mem_ready pulsed → after reset every fetch misses. While rdy_in=0, mem_addr and cnt are unchanged and the pulsed word is not captured.
